// File: rtl/bme280_i2c_slave.sv
// bme280_i2c_slave: oversampled I2C target that maps one slave address onto a single-port register bus
module bme280_i2c_slave #(
  parameter int DWIDTH = 8,
  parameter logic [6:0] SLADDR = 7'b111_0110
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Scl_i,
  input  logic              Sda_i,
  output logic              Sda_oe,
  output logic [DWIDTH-1:0] Reg_addr,
  output logic [DWIDTH-1:0] Reg_wdata,
  output logic              Reg_wr,
  output logic              Reg_rd,
  input  logic [DWIDTH-1:0] Reg_rdata,
  output logic              Busy
);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, RADDR, RADDR_ACK, WDATA, WDATA_ACK, RDATA, MACK, WAIT_STOP} state_t;
  state_t state, state_n;
  logic [2:0] scl_q, sda_q;
  logic [2:0] cnt, cnt_n;
  logic [DWIDTH-2:0] sr, sr_n;
  logic [DWIDTH-1:0] tx, tx_n, addr_n, wdata_n, byte_in;
  logic scl_rise, scl_fall, start, stop, last, match;
  logic oe_n, wr_n, busy_n, rw, rw_n, acked, acked_n;
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start = scl_q[1] & sda_q[2] & ~sda_q[1];
  assign stop = scl_q[1] & ~sda_q[2] & sda_q[1];
  assign byte_in = {sr, sda_q[1]};
  assign last = cnt == 3'd7;
  assign match = byte_in[DWIDTH-1:1] == SLADDR;
  assign Reg_rd = scl_fall & ((state == ADDR_ACK & Sda_oe & rw) | (state == MACK & acked));
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
    tx_n = tx;
    addr_n = Reg_addr;
    wdata_n = Reg_wdata;
    oe_n = Sda_oe;
    wr_n = 1'b0;
    busy_n = Busy;
    rw_n = rw;
    acked_n = acked;
    if (stop) begin
      state_n = IDLE;
      oe_n = 1'b0;
      busy_n = 1'b0;
      acked_n = 1'b0;
    end else if (start) begin
      state_n = ADDR;
      cnt_n = '0;
      oe_n = 1'b0;
      acked_n = 1'b0;
    end else if (Reg_rd) begin
      state_n = RDATA;
      oe_n = ~Reg_rdata[DWIDTH-1];
      tx_n = {Reg_rdata[DWIDTH-2:0], 1'b1};
      acked_n = 1'b0;
    end else if (scl_rise) begin
      if (state inside {ADDR, RADDR, WDATA, RDATA}) begin
        cnt_n = cnt + 3'd1;
        sr_n = byte_in[DWIDTH-2:0];
      end
      case (state)
        ADDR: if (last) begin
          state_n = match ? ADDR_ACK : WAIT_STOP;
          busy_n = Busy | match;
          rw_n = byte_in[0];
        end
        RADDR: if (last) begin
          state_n = RADDR_ACK;
          addr_n = byte_in;
        end
        WDATA: if (last) begin
          state_n = WDATA_ACK;
          wdata_n = byte_in;
          wr_n = 1'b1;
        end
        RDATA: if (last) state_n = MACK;
        MACK: begin
          acked_n = ~sda_q[1];
          addr_n = sda_q[1] ? Reg_addr : Reg_addr + DWIDTH'(1);
          state_n = sda_q[1] ? WAIT_STOP : MACK;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        ADDR_ACK, RADDR_ACK, WDATA_ACK: begin
          oe_n = ~Sda_oe;
          if (Sda_oe) state_n = state == ADDR_ACK ? RADDR : WDATA;
          if (Sda_oe && state == WDATA_ACK) addr_n = Reg_addr + DWIDTH'(1);
        end
        RDATA: begin
          oe_n = ~tx[DWIDTH-1];
          tx_n = {tx[DWIDTH-2:0], 1'b1};
        end
        MACK: oe_n = 1'b0;
        default: ;
      endcase
    end
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      tx <= '0;
      Sda_oe <= 1'b0;
      Reg_addr <= '0;
      Reg_wdata <= '0;
      Reg_wr <= 1'b0;
      Busy <= 1'b0;
      rw <= 1'b0;
      acked <= 1'b0;
    end else begin
      scl_q <= {scl_q[1:0], Scl_i};
      sda_q <= {sda_q[1:0], Sda_i};
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
      tx <= tx_n;
      Sda_oe <= oe_n;
      Reg_addr <= addr_n;
      Reg_wdata <= wdata_n;
      Reg_wr <= wr_n;
      Busy <= busy_n;
      rw <= rw_n;
      acked <= acked_n;
    end
  end
endmodule

// File: tb/tb_bme280_i2c_slave.sv
// tb_bme280_i2c_slave: bit-banged I2C master against a register bank and a behavioural memory/pointer model
module tb_bme280_i2c_slave;
  typedef struct {
    logic [7:0] dev, ptr;
    int n;
    logic [2:0][7:0] d;
    logic exp_ack;
    int exp_nwr;
    logic [2:0][7:0] exp_a;
    logic [7:0] exp_ptr;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic sda_oe, reg_wr, reg_rd, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic [7:0] regs [256];
  logic [7:0] mem_ref [256];
  logic [7:0] ptr_ref;
  logic [15:0] wq [$];
  int n_rd = 0, n_chk = 0, n_fail = 0;
  wire sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;
  bme280_i2c_slave dut (
    .Clk(clk), .Rst_n(rst_n), .Scl_i(scl_m), .Sda_i(sda_line), .Sda_oe(sda_oe),
    .Reg_addr(reg_addr), .Reg_wdata(reg_wdata), .Reg_wr(reg_wr), .Reg_rd(reg_rd),
    .Reg_rdata(reg_rdata), .Busy(busy)
  );
  assign reg_rdata = regs[reg_addr];
  always @(posedge clk) if (reg_wr) regs[reg_addr] <= reg_wdata;
  always @(negedge clk) begin
    if (reg_wr) wq.push_back({reg_addr, reg_wdata});
    if (reg_rd) n_rd++;
  end
  initial begin
    #600000;
    $display("FAIL watchdog: bench still running, required finish before 60000 clocks");
    $fatal(1, "timeout");
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic bus_bit(input logic b, output logic r);
    sda_m = b;
    tick(4);
    scl_m = 1'b1;
    tick(4);
    r = sda_line;
    tick(4);
    scl_m = 1'b0;
    tick(4);
  endtask
  task automatic i2c_start();
    sda_m = 1'b1;
    tick(4);
    scl_m = 1'b1;
    tick(4);
    sda_m = 1'b0;
    tick(4);
    scl_m = 1'b0;
    tick(4);
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0;
    tick(4);
    scl_m = 1'b1;
    tick(4);
    sda_m = 1'b1;
    tick(4);
  endtask
  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
    bus_bit(1'b1, r);
    ack = ~r;
  endtask
  task automatic rd_byte(input logic ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      d[i] = r;
    end
    bus_bit(~ack, r);
  endtask
  initial begin
    vec_t vt [4];
    logic ack, r;
    logic [7:0] d, p, a;
    int n, rd0;
    vt[0] = '{8'hEC, 8'hF4, 1, {8'h00, 8'h00, 8'h27}, 1'b1, 1, {8'h00, 8'h00, 8'hF4}, 8'hF5};
    vt[1] = '{8'hEC, 8'hFE, 3, {8'h33, 8'h22, 8'h11}, 1'b1, 3, {8'h00, 8'hFF, 8'hFE}, 8'h01};
    vt[2] = '{8'hEE, 8'h55, 1, {8'h00, 8'h00, 8'h77}, 1'b0, 0, {8'h00, 8'h00, 8'h00}, 8'h01};
    vt[3] = '{8'hEC, 8'h10, 0, {8'h00, 8'h00, 8'h00}, 1'b1, 0, {8'h00, 8'h00, 8'h00}, 8'h10};
    for (int i = 0; i < 256; i++) begin
      regs[i] <= 8'(i) ^ 8'h5A;
      mem_ref[i] = 8'(i) ^ 8'h5A;
    end
    regs[8'hD0] <= 8'h60;
    regs[8'hD1] <= 8'hA5;
    mem_ref[8'hD0] = 8'h60;
    mem_ref[8'hD1] = 8'hA5;
    tick(3);
    check("rst_oe", sda_oe, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_wr", reg_wr, 0);
    check("rst_rd", reg_rd, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(4);
    for (int v = 0; v < 4; v++) begin
      wq.delete();
      i2c_start();
      wr_byte(vt[v].dev, ack);
      check("vec_dev_ack", ack, vt[v].exp_ack);
      check("vec_busy", busy, vt[v].exp_ack);
      wr_byte(vt[v].ptr, ack);
      check("vec_ptr_ack", ack, vt[v].exp_ack);
      for (int i = 0; i < vt[v].n; i++) begin
        wr_byte(vt[v].d[i], ack);
        check("vec_data_ack", ack, vt[v].exp_ack);
      end
      i2c_stop();
      check("vec_busy_idle", busy, 0);
      check("vec_nwr", wq.size(), vt[v].exp_nwr);
      for (int i = 0; i < vt[v].exp_nwr; i++) begin
        if (i < wq.size()) begin
          check("vec_waddr", wq[i][15:8], vt[v].exp_a[i]);
          check("vec_wdata", wq[i][7:0], vt[v].d[i]);
        end
        mem_ref[vt[v].exp_a[i]] = vt[v].d[i];
      end
      check("vec_ptr", reg_addr, vt[v].exp_ptr);
    end
    rd0 = n_rd;
    i2c_start();
    wr_byte(8'hEC, ack);
    check("rr_dev_ack", ack, 1);
    wr_byte(8'hD0, ack);
    check("rr_ptr_ack", ack, 1);
    i2c_start();
    wr_byte(8'hED, ack);
    check("rr_rdev_ack", ack, 1);
    rd_byte(1'b1, d);
    check("rr_byte0", d, 8'h60);
    rd_byte(1'b0, d);
    check("rr_byte1", d, 8'hA5);
    check("rr_nrd", n_rd - rd0, 2);
    bus_bit(1'b0, r);
    check("rr_wait_oe", sda_oe, 0);
    check("rr_wait_busy", busy, 1);
    i2c_stop();
    check("rr_busy_idle", busy, 0);
    check("rr_ptr", reg_addr, 8'hD1);
    wq.delete();
    i2c_start();
    wr_byte(8'hEC, ack);
    wr_byte(8'h40, ack);
    check("ab_ptr_ack", ack, 1);
    for (int i = 0; i < 4; i++) bus_bit(i[0], r);
    i2c_stop();
    check("ab_nwr", wq.size(), 0);
    check("ab_busy", busy, 0);
    i2c_start();
    wr_byte(8'hEC, ack);
    check("ab2_dev_ack", ack, 1);
    wr_byte(8'h41, ack);
    wr_byte(8'h99, ack);
    check("ab2_data_ack", ack, 1);
    i2c_stop();
    check("ab2_nwr", wq.size(), 1);
    if (wq.size() > 0) begin
      check("ab2_waddr", wq[0][15:8], 8'h41);
      check("ab2_wdata", wq[0][7:0], 8'h99);
    end
    mem_ref[8'h41] = 8'h99;
    i2c_start();
    wr_byte(8'hEC, ack);
    wr_byte(8'hD0, ack);
    i2c_start();
    wr_byte(8'hED, ack);
    check("rm_ack", ack, 1);
    check("rm_drive0", sda_oe, 1);
    rst_n = 1'b0;
    tick(1);
    check("rm_oe", sda_oe, 0);
    check("rm_busy", busy, 0);
    check("rm_addr", reg_addr, 0);
    check("rm_wdata", reg_wdata, 0);
    check("rm_wr", reg_wr, 0);
    check("rm_rd", reg_rd, 0);
    rst_n = 1'b1;
    sda_m = 1'b1;
    scl_m = 1'b1;
    tick(8);
    ptr_ref = 8'h00;
    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        p = 8'($urandom);
        n = $urandom_range(1, 4);
        i2c_start();
        wr_byte(8'hEC, ack);
        wr_byte(p, ack);
        check("rnd_wptr_ack", ack, 1);
        for (int i = 0; i < n; i++) begin
          d = 8'($urandom);
          a = p + 8'(i);
          mem_ref[a] = d;
          wr_byte(d, ack);
          check("rnd_wdata_ack", ack, 1);
        end
        i2c_stop();
        ptr_ref = p + 8'(n);
      end else begin
        n = $urandom_range(1, 4);
        rd0 = n_rd;
        i2c_start();
        wr_byte(8'hED, ack);
        check("rnd_rdev_ack", ack, 1);
        for (int i = 0; i < n; i++) begin
          rd_byte(i != n - 1, d);
          a = ptr_ref + 8'(i);
          check("rnd_rdata", d, mem_ref[a]);
        end
        i2c_stop();
        check("rnd_nrd", n_rd - rd0, n);
        ptr_ref = ptr_ref + 8'(n - 1);
      end
      check("rnd_ptr", reg_addr, ptr_ref);
      check("rnd_busy", busy, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
